// File: rtl/uart_reg_responder.sv
// uart_reg_responder: parses W/R command frames arriving from the UART receive
// side, performs a single register bus write or read, and answers with one byte
// through the UART transmit handshake. All outputs come straight from flops.
module uart_reg_responder #(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       rx_drop,
  output logic       frame_timeout
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  // The inter-byte timer only ever needs to count up to TIMEOUT_CYCLES-1.
  localparam int             TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS_WR,
    BUS_RD,
    RD_WAIT,
    SEND,
    WAIT_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          cmd_write_q, cmd_write_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [7:0]    tx_data_d;
  logic          tx_data_valid_d;
  logic [7:0]    reg_addr_d;
  logic [7:0]    reg_wdata_d;
  logic          reg_we_d;
  logic          reg_re_d;
  logic          rx_drop_d;
  logic          frame_timeout_d;

  // Response launch request raised by the states that produce a reply byte.
  logic          load_resp;
  logic [7:0]    resp_byte;

  // Next-state and next-output decode. Every output is computed one cycle
  // ahead here and registered below, so a reply that finds the transmitter
  // idle is requested in the very cycle the FSM would otherwise enter SEND;
  // SEND itself is only occupied while the transmitter is busy.
  always_comb begin
    state_d         = state_q;
    cmd_write_d     = cmd_write_q;
    timer_d         = '0;
    tx_data_d       = tx_data;
    tx_data_valid_d = 1'b0;
    reg_addr_d      = reg_addr;
    reg_wdata_d     = reg_wdata;
    reg_we_d        = 1'b0;
    reg_re_d        = 1'b0;
    rx_drop_d       = 1'b0;
    frame_timeout_d = 1'b0;
    load_resp       = 1'b0;
    resp_byte       = tx_data;

    case (state_q)
      IDLE: begin
        if (rx_data_valid) begin
          if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
            cmd_write_d = (rx_data == CMD_WRITE);
            state_d     = GET_ADDR;
          end else begin
            load_resp = 1'b1;
            resp_byte = NAK_BYTE;
          end
        end
      end

      GET_ADDR: begin
        if (rx_data_valid) begin
          reg_addr_d = rx_data;
          if (cmd_write_q) begin
            state_d = GET_DATA;
          end else begin
            state_d  = BUS_RD;
            reg_re_d = 1'b1;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d         = IDLE;
          frame_timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      GET_DATA: begin
        if (rx_data_valid) begin
          reg_wdata_d = rx_data;
          state_d     = BUS_WR;
          reg_we_d    = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          state_d         = IDLE;
          frame_timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      BUS_WR: begin
        load_resp = 1'b1;
        resp_byte = ACK_BYTE;
      end

      BUS_RD: begin
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        load_resp = 1'b1;
        resp_byte = reg_rdata;
      end

      SEND: begin
        if (!tx_busy) begin
          tx_data_valid_d = 1'b1;
          state_d         = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (tx_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_resp) begin
      tx_data_d = resp_byte;
      if (!tx_busy) begin
        tx_data_valid_d = 1'b1;
        state_d         = WAIT_DONE;
      end else begin
        state_d = SEND;
      end
    end

    if (rx_data_valid && (state_q inside {BUS_WR, BUS_RD, RD_WAIT, SEND, WAIT_DONE})) begin
      rx_drop_d = 1'b1;
    end
  end

  // State, timer and registered outputs; reset aborts any frame or reply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_write_q   <= 1'b0;
      timer_q       <= '0;
      tx_data       <= 8'h00;
      tx_data_valid <= 1'b0;
      reg_addr      <= 8'h00;
      reg_wdata     <= 8'h00;
      reg_we        <= 1'b0;
      reg_re        <= 1'b0;
      busy          <= 1'b0;
      rx_drop       <= 1'b0;
      frame_timeout <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_write_q   <= cmd_write_d;
      timer_q       <= timer_d;
      tx_data       <= tx_data_d;
      tx_data_valid <= tx_data_valid_d;
      reg_addr      <= reg_addr_d;
      reg_wdata     <= reg_wdata_d;
      reg_we        <= reg_we_d;
      reg_re        <= reg_re_d;
      busy          <= (state_d != IDLE);
      rx_drop       <= rx_drop_d;
      frame_timeout <= frame_timeout_d;
    end
  end

endmodule
